reg_rename_file: RTL and testbench

- Architectural register file plus per-register rename tags. Sits directly downstream of the reorder buffer's commit port.
- Consumes the ROB commit stream (reg id, alias, result) and the dispatcher's rename requests.
- Serves dispatch with a source operand value, or with the ROB alias that will produce it.
- Tag value 0 means "no pending producer"; ROB alias 0 is never allocated.

---
 rtl/reg_rename_file_pkg.sv | 13 +
 rtl/reg_rename_file_read_port.sv | 45 ++++
 rtl/reg_rename_file.sv | 101 ++++++++++
 tb/tb_reg_rename_file.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_rename_file_pkg.sv
// Shared sizing constants for the architectural register file and its rename tags.
// Alias 0 is reserved as "no pending producer", and register x0 reads as zero.
package reg_rename_file_pkg;

   localparam int RF_REG_NUM = 32;
   localparam int RF_REG_W   = 5;
   localparam int RF_ROB_W   = 4;
   localparam int RF_XLEN    = 32;

   localparam int NO_ALIAS   = 0;
   localparam int X0_IDX     = 0;

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One dispatch read port: tag/value lookup with a same-cycle commit bypass.
// Reads of x0 are forced to Q=0, V=0.
module rf_read_port
   import reg_rename_file_pkg::*;
#(
   parameter int REG_NUM = RF_REG_NUM,
   parameter int REG_W   = RF_REG_W,
   parameter int ROB_W   = RF_ROB_W,
   parameter int XLEN    = RF_XLEN
) (
   input  logic [REG_W-1:0] rs,
   input  logic [ROB_W-1:0] tag_tbl   [REG_NUM],
   input  logic [XLEN-1:0]  value_tbl [REG_NUM],
   input  logic             commit_valid,
   input  logic [REG_W-1:0] commit_rd,
   input  logic [ROB_W-1:0] commit_alias,
   input  logic [XLEN-1:0]  commit_data,
   output logic [ROB_W-1:0] q,
   output logic [XLEN-1:0]  v
);

   logic             rs_is_x0;
   logic [ROB_W-1:0] rs_tag;
   logic             bypass_hit;

   assign rs_is_x0   = (rs == REG_W'(X0_IDX));
   assign rs_tag     = tag_tbl[rs];
   // A younger rename leaves a different tag in place, which blocks the bypass.
   assign bypass_hit = commit_valid && (commit_rd == rs) && !rs_is_x0
                       && (rs_tag == commit_alias);

   always_comb begin
      q = rs_tag;
      v = value_tbl[rs];
      if (bypass_hit) begin
         q = ROB_W'(NO_ALIAS);
         v = commit_data;
      end
      if (rs_is_x0) begin
         q = ROB_W'(NO_ALIAS);
         v = '0;
      end
   end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags, fed by the ROB commit
// port and the dispatcher's rename requests; serves two dispatch source operands.
module reg_rename_file
   import reg_rename_file_pkg::*;
#(
   parameter int REG_NUM = RF_REG_NUM,
   parameter int REG_W   = RF_REG_W,
   parameter int ROB_W   = RF_ROB_W,
   parameter int XLEN    = RF_XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             commit_valid,
   input  logic [REG_W-1:0] commit_rd,
   input  logic [ROB_W-1:0] commit_alias,
   input  logic [XLEN-1:0]  commit_data,
   input  logic             rename_valid,
   input  logic [REG_W-1:0] rename_rd,
   input  logic [ROB_W-1:0] rename_alias,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   output logic [ROB_W-1:0] Qi,
   output logic [XLEN-1:0]  Vi,
   output logic [ROB_W-1:0] Qj,
   output logic [XLEN-1:0]  Vj
);

   logic [XLEN-1:0]  value_q [REG_NUM];
   logic [ROB_W-1:0] tag_q   [REG_NUM];

   logic commit_we;
   logic commit_clr_tag;
   logic rename_we;

   assign commit_we      = rdy && commit_valid && (commit_rd != REG_W'(X0_IDX));
   assign commit_clr_tag = commit_we && (tag_q[commit_rd] == commit_alias);
   assign rename_we      = rdy && rename_valid && !rollback
                           && (rename_rd != REG_W'(X0_IDX));

   // Later assignments win: rollback clears over commit, rename tag over commit clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= ROB_W'(NO_ALIAS);
         end
      end else begin
         if (commit_we) begin
            value_q[commit_rd] <= commit_data;
         end
         if (commit_clr_tag) begin
            tag_q[commit_rd] <= ROB_W'(NO_ALIAS);
         end
         if (rdy && rollback) begin
            for (int i = 0; i < REG_NUM; i++) begin
               tag_q[i] <= ROB_W'(NO_ALIAS);
            end
         end
         if (rename_we) begin
            tag_q[rename_rd] <= rename_alias;
         end
      end
   end

   rf_read_port #(
      .REG_NUM (REG_NUM),
      .REG_W   (REG_W),
      .ROB_W   (ROB_W),
      .XLEN    (XLEN)
   ) u_read_rs1 (
      .rs           (rs1),
      .tag_tbl      (tag_q),
      .value_tbl    (value_q),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_alias (commit_alias),
      .commit_data  (commit_data),
      .q            (Qi),
      .v            (Vi)
   );

   rf_read_port #(
      .REG_NUM (REG_NUM),
      .REG_W   (REG_W),
      .ROB_W   (ROB_W),
      .XLEN    (XLEN)
   ) u_read_rs2 (
      .rs           (rs2),
      .tag_tbl      (tag_q),
      .value_tbl    (value_q),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_alias (commit_alias),
      .commit_data  (commit_data),
      .q            (Qj),
      .v            (Vj)
   );

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: reset, rename/commit, bypass, rollback, x0 and stall.
module tb_reg_rename_file;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        rollback;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [3:0]  commit_alias;
   logic [31:0] commit_data;
   logic        rename_valid;
   logic [4:0]  rename_rd;
   logic [3:0]  rename_alias;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [3:0]  Qi;
   logic [31:0] Vi;
   logic [3:0]  Qj;
   logic [31:0] Vj;

   int n_vec;
   int n_miss;

   reg_rename_file dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .rollback     (rollback),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_alias (commit_alias),
      .commit_data  (commit_data),
      .rename_valid (rename_valid),
      .rename_rd    (rename_rd),
      .rename_alias (rename_alias),
      .rs1          (rs1),
      .rs2          (rs2),
      .Qi           (Qi),
      .Vi           (Vi),
      .Qj           (Qj),
      .Vj           (Vj)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rollback     = 1'b0;
      commit_valid = 1'b0;
      commit_rd    = '0;
      commit_alias = '0;
      commit_data  = '0;
      rename_valid = 1'b0;
      rename_rd    = '0;
      rename_alias = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_rename(input logic [4:0] rd, input logic [3:0] alias_id);
      rename_valid = 1'b1;
      rename_rd    = rd;
      rename_alias = alias_id;
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [3:0] alias_id, input logic [31:0] data);
      commit_valid = 1'b1;
      commit_rd    = rd;
      commit_alias = alias_id;
      commit_data  = data;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      rst    = 1'b0;
      rdy    = 1'b1;
      idle();
      rs1 = 5'd3;
      rs2 = 5'd0;
      #2;
      check_vec("reset_Qi", 32'(Qi), 32'h0);
      check_vec("reset_Vi", Vi, 32'h0);
      check_vec("reset_Qj", 32'(Qj), 32'h0);
      check_vec("reset_Vj", Vj, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Rename x5 -> 2, then commit it
      do_rename(5'd5, 4'd2);
      tick();
      idle();
      rs1 = 5'd5;
      #1;
      check_vec("ren_x5_Qi", 32'(Qi), 32'd2);
      do_commit(5'd5, 4'd2, 32'hDEADBEEF);
      #1;
      check_vec("byp_x5_Qi", 32'(Qi), 32'd0);
      check_vec("byp_x5_Vi", Vi, 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check_vec("cmt_x5_Qi", 32'(Qi), 32'd0);
      check_vec("cmt_x5_Vi", Vi, 32'hDEADBEEF);

      // Younger rename survives an older commit
      do_rename(5'd5, 4'd2);
      tick();
      do_rename(5'd5, 4'd7);
      tick();
      idle();
      do_commit(5'd5, 4'd2, 32'h11);
      #1;
      check_vec("old_cmt_byp_Qi", 32'(Qi), 32'd7);
      check_vec("old_cmt_byp_Vi", Vi, 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check_vec("old_cmt_Qi", 32'(Qi), 32'd7);
      check_vec("old_cmt_Vi", Vi, 32'h11);

      // Commit bypass on rs2
      do_rename(5'd6, 4'd3);
      tick();
      idle();
      rs2 = 5'd6;
      do_commit(5'd6, 4'd3, 32'h42);
      #1;
      check_vec("byp_x6_Qj", 32'(Qj), 32'd0);
      check_vec("byp_x6_Vj", Vj, 32'h42);
      tick();
      idle();
      #1;
      check_vec("cmt_x6_Qj", 32'(Qj), 32'd0);
      check_vec("cmt_x6_Vj", Vj, 32'h42);

      // Same-cycle commit and rename on one register: rename tag wins, value written
      do_rename(5'd7, 4'd6);
      tick();
      do_commit(5'd7, 4'd6, 32'h77);
      do_rename(5'd7, 4'd9);
      tick();
      idle();
      rs1 = 5'd7;
      #1;
      check_vec("same_cyc_Qi", 32'(Qi), 32'd9);
      check_vec("same_cyc_Vi", Vi, 32'h77);

      // Rollback with same-cycle commit and rename
      do_rename(5'd1, 4'd1);
      tick();
      do_rename(5'd2, 4'd4);
      tick();
      idle();
      rs1 = 5'd1;
      rs2 = 5'd2;
      #1;
      check_vec("pre_rb_Qi", 32'(Qi), 32'd1);
      check_vec("pre_rb_Qj", 32'(Qj), 32'd4);
      rollback = 1'b1;
      do_commit(5'd1, 4'd1, 32'h100);
      do_rename(5'd3, 4'd5);
      tick();
      idle();
      #1;
      check_vec("rb_x1_Qi", 32'(Qi), 32'd0);
      check_vec("rb_x1_Vi", Vi, 32'h100);
      check_vec("rb_x2_Qj", 32'(Qj), 32'd0);
      rs1 = 5'd3;
      rs2 = 5'd5;
      #1;
      check_vec("rb_x3_Qi", 32'(Qi), 32'd0);
      check_vec("rb_x5_Qj", 32'(Qj), 32'd0);
      check_vec("rb_x5_Vj", Vj, 32'h11);
      rs1 = 5'd7;
      #1;
      check_vec("rb_x7_Qi", 32'(Qi), 32'd0);

      // x0 writes and renames are dropped
      do_rename(5'd0, 4'd3);
      do_commit(5'd0, 4'd3, 32'hFF);
      rs1 = 5'd0;
      #1;
      check_vec("x0_byp_Vi", Vi, 32'h0);
      tick();
      idle();
      #1;
      check_vec("x0_Qi", 32'(Qi), 32'd0);
      check_vec("x0_Vi", Vi, 32'h0);

      // Stall: nothing changes while rdy is low
      rdy = 1'b0;
      do_rename(5'd4, 4'd8);
      do_commit(5'd6, 4'd5, 32'h55);
      tick();
      tick();
      idle();
      rdy = 1'b1;
      rs1 = 5'd4;
      rs2 = 5'd6;
      #1;
      check_vec("stall_x4_Qi", 32'(Qi), 32'd0);
      check_vec("stall_x6_Vj", Vj, 32'h42);
      tick();
      check_vec("post_stall_x4_Qi", 32'(Qi), 32'd0);
      check_vec("post_stall_x6_Vj", Vj, 32'h42);

      // Asynchronous reset mid-run, away from any clock edge
      do_rename(5'd4, 4'd8);
      tick();
      idle();
      rs1 = 5'd4;
      rs2 = 5'd6;
      #1;
      check_vec("pre_arst_Qi", 32'(Qi), 32'd8);
      #1;
      rst = 1'b0;
      #1;
      check_vec("arst_Qi", 32'(Qi), 32'd0);
      check_vec("arst_Vj", Vj, 32'h0);
      rs1 = 5'd7;
      #1;
      check_vec("arst_x7_Vi", Vi, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
